// File: rtl/vpu_pkg.sv
// Shared constants for the VPU execution unit: opcodes, instruction field
// positions, flag bit indices and the sequencing state type.
package vpu_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'b00000;
   localparam logic [4:0] OP_MOV     = 5'b00001;
   localparam logic [4:0] OP_ADD     = 5'b00010;
   localparam logic [4:0] OP_SUB     = 5'b00011;
   localparam logic [4:0] OP_MUL     = 5'b00100;
   localparam logic [4:0] OP_OR      = 5'b00101;
   localparam logic [4:0] OP_AND     = 5'b00110;
   localparam logic [4:0] OP_XOR     = 5'b00111;
   localparam logic [4:0] OP_XNOR    = 5'b01000;
   localparam logic [4:0] OP_NAND    = 5'b01001;
   localparam logic [4:0] OP_NOR     = 5'b01010;
   localparam logic [4:0] OP_NOT     = 5'b01011;

   localparam int OPC_LO       = 27;
   localparam int RDST_LO      = 22;
   localparam int RSRC1_LO     = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_LO     = 11;
   localparam int IMM_W        = 16;

   localparam int FLG_S = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } vpu_state_t;

endpackage

// File: rtl/vpu_mul.sv
// Multi-cycle unsigned multiplier with start/valid handshake.
// Only built when VPU_MUL_EN is defined.
`ifdef VPU_MUL_EN
module vpu_mul
   import vpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  valid,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CW = $clog2(MUL_LAT + 1);

   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [CW-1:0]     cnt;

   // Operands are captured at start so the source registers may be rewritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         cnt <= '0;
      end else if (start) begin
         a_q <= a;
         b_q <= b;
         cnt <= CW'(MUL_LAT - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   if (MUL_LAT == 1) begin : g_comb
      assign valid   = start;
      assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   end else begin : g_seq
      assign valid   = (cnt == CW'(1));
      assign product = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
   end

endmodule
`endif

// File: rtl/vpu_exec_unit.sv
// VPU execution unit: GPR file, ALU, flags and optional multiplier.
// Multiplier and MUL_BUSY sequencing are present only when VPU_MUL_EN is defined.
//
// state       | meaning
// ST_IDLE     | ready; non-mul ops retire the cycle after acceptance
// ST_MUL_BUSY | multiply in flight; new instructions are held off
module vpu_exec_unit
   import vpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NREGS   = 32,
   parameter int MUL_LAT = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              done,
   output logic              err,
   output logic [3:0]        flags,
   output logic [DATA_W-1:0] sgpr,
   input  logic [4:0]        dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int M  = DATA_W - 1;

   logic [DATA_W-1:0] gpr [NREGS];

   logic [4:0]        opcode;
   logic [AW-1:0]     rdst, rsrc1, rsrc2;
   logic              imm_mode;
   logic [DATA_W-1:0] imm_ext, src1, src2, res;
   logic              carry, ovf, wr_en, upd_flags, illegal, is_mul, accept;
   logic [3:0]        alu_flags;

`ifdef VPU_MUL_EN
   vpu_state_t          state;
   logic [AW-1:0]       mul_rdst_q, mul_rdst;
   logic                mul_valid;
   logic [2*DATA_W-1:0] product;
   logic [DATA_W-1:0]   sgpr_q;
   logic [3:0]          mul_flags;
`endif

   assign opcode   = instr[OPC_LO +: 5];
   assign rdst     = instr[RDST_LO +: AW];
   assign rsrc1    = instr[RSRC1_LO +: AW];
   assign rsrc2    = instr[RSRC2_LO +: AW];
   assign imm_mode = instr[IMM_MODE_BIT];
   assign imm_ext  = DATA_W'(instr[IMM_W-1:0]);
   assign accept   = instr_valid && instr_ready;

   assign dbg_rdata = ({27'd0, dbg_raddr} < 32'(NREGS)) ? gpr[dbg_raddr[AW-1:0]] : '0;

   always_comb begin
      src1      = gpr[rsrc1];
      src2      = imm_mode ? imm_ext : gpr[rsrc2];
      res       = '0;
      carry     = 1'b0;
      ovf       = 1'b0;
      wr_en     = 1'b0;
      upd_flags = 1'b0;
      illegal   = 1'b0;
      is_mul    = 1'b0;
      case (opcode)
         OP_MOV:  begin res = src2; wr_en = 1'b1; end
         OP_ADD: begin
            {carry, res} = {1'b0, src1} + {1'b0, src2};
            ovf   = (src1[M] == src2[M]) && (res[M] != src1[M]);
            wr_en = 1'b1; upd_flags = 1'b1;
         end
         // Top bit of the widened difference is the borrow.
         OP_SUB: begin
            {carry, res} = {1'b0, src1} - {1'b0, src2};
            ovf   = (src1[M] != src2[M]) && (res[M] != src1[M]);
            wr_en = 1'b1; upd_flags = 1'b1;
         end
         OP_OR:   begin res = src1 | src2;    wr_en = 1'b1; upd_flags = 1'b1; end
         OP_AND:  begin res = src1 & src2;    wr_en = 1'b1; upd_flags = 1'b1; end
         OP_XOR:  begin res = src1 ^ src2;    wr_en = 1'b1; upd_flags = 1'b1; end
         OP_XNOR: begin res = ~(src1 ^ src2); wr_en = 1'b1; upd_flags = 1'b1; end
         OP_NAND: begin res = ~(src1 & src2); wr_en = 1'b1; upd_flags = 1'b1; end
         OP_NOR:  begin res = ~(src1 | src2); wr_en = 1'b1; upd_flags = 1'b1; end
         OP_NOT:  begin res = ~src2;          wr_en = 1'b1; upd_flags = 1'b1; end
`ifdef VPU_MUL_EN
         OP_MOVSGPR: begin res = sgpr_q; wr_en = 1'b1; end
         OP_MUL:     is_mul = 1'b1;
`endif
         default: illegal = 1'b1;
      endcase
      alu_flags        = '0;
      alu_flags[FLG_S] = res[M];
      alu_flags[FLG_Z] = (res == '0);
      alu_flags[FLG_C] = carry;
      alu_flags[FLG_V] = ovf;
   end

`ifdef VPU_MUL_EN
   vpu_mul #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && is_mul),
      .a       (src1),
      .b       (src2),
      .valid   (mul_valid),
      .product (product)
   );

   assign mul_rdst = (MUL_LAT == 1) ? rdst : mul_rdst_q;
   assign sgpr     = sgpr_q;

   always_comb begin
      mul_flags        = '0;
      mul_flags[FLG_S] = product[M];
      mul_flags[FLG_Z] = (product[DATA_W-1:0] == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         instr_ready <= 1'b1;
         mul_rdst_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && is_mul && (MUL_LAT > 1)) begin
                  state       <= ST_MUL_BUSY;
                  instr_ready <= 1'b0;
                  mul_rdst_q  <= rdst;
               end
            end
            ST_MUL_BUSY: begin
               if (mul_valid) begin
                  state       <= ST_IDLE;
                  instr_ready <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end
`else
   assign sgpr        = '0;
   assign instr_ready = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
         flags <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
`ifdef VPU_MUL_EN
         sgpr_q <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (accept && !is_mul) begin
            done <= 1'b1;
            err  <= illegal;
            if (wr_en)     gpr[rdst] <= res;
            if (upd_flags) flags     <= alu_flags;
         end
`ifdef VPU_MUL_EN
         if (mul_valid) begin
            done          <= 1'b1;
            gpr[mul_rdst] <= product[DATA_W-1:0];
            sgpr_q        <= product[2*DATA_W-1:DATA_W];
            flags         <= mul_flags;
         end
`endif
      end
   end

endmodule

// File: tb/tb_vpu_exec_unit.sv
// Directed, table-driven bench for vpu_exec_unit (both VPU_MUL_EN builds).
`timescale 1ns/1ps
module tb_vpu_exec_unit;
   import vpu_pkg::*;

   localparam int DATA_W  = 32;
   localparam int NREGS   = 32;
   localparam int MUL_LAT = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic              done;
   logic              err;
   logic [3:0]        flags;
   logic [DATA_W-1:0] sgpr;
   logic [4:0]        dbg_raddr;
   logic [DATA_W-1:0] dbg_rdata;

   always #5 clk = ~clk;

   vpu_exec_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .MUL_LAT(MUL_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .done        (done),
      .err         (err),
      .flags       (flags),
      .sgpr        (sgpr),
      .dbg_raddr   (dbg_raddr),
      .dbg_rdata   (dbg_rdata)
   );

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rg;
      logic [31:0] val;
      logic [3:0]  flg;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] enc_i(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [15:0] imm);
      return {op, rd, rs1, 1'b1, imm};
   endfunction

   function automatic logic [31:0] enc_r(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2);
      return {op, rd, rs1, 1'b0, rs2, 11'd0};
   endfunction

   function automatic vec_t mk(logic [31:0] ins, logic [4:0] rg, logic [31:0] val,
                               logic [3:0] flg, logic e);
      vec_t v;
      v.instr = ins; v.rg = rg; v.val = val; v.flg = flg; v.err = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      instr       = v.instr;
      instr_valid = 1'b1;
      dbg_raddr   = v.rg;
      @(posedge clk); #1;
      chk({nm, "_done"},  done,      1);
      chk({nm, "_err"},   err,       v.err);
      chk({nm, "_reg"},   dbg_rdata, v.val);
      chk({nm, "_flags"}, flags,     v.flg);
   endtask

   task automatic gprs_zero(input string nm);
      int nz = 0;
      for (int i = 0; i < NREGS; i++) begin
         dbg_raddr = 5'(i);
         #1;
         if (dbg_rdata !== '0) nz++;
      end
      chk(nm, nz, 0);
   endtask

`ifdef VPU_MUL_EN
   task automatic do_mul(input logic [31:0] ins, input logic [4:0] rg, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [3:0] flg, input string nm);
      int busy   = 0;
      int waited = 0;
      @(negedge clk);
      instr       = ins;
      instr_valid = 1'b1;
      dbg_raddr   = rg;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      while (!done && waited < 20) begin
         if (!instr_ready) busy++;
         waited++;
         @(posedge clk); #1;
      end
      chk({nm, "_done"},  done,      1);
      chk({nm, "_busy"},  busy,      MUL_LAT - 1);
      chk({nm, "_err"},   err,       0);
      chk({nm, "_lo"},    dbg_rdata, lo);
      chk({nm, "_sgpr"},  sgpr,      hi);
      chk({nm, "_flags"}, flags,     flg);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dv;
      logic        done_seen;

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      dbg_raddr   = '0;
      repeat (2) @(negedge clk);
      chk("rst_done_low", done, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_done",  done,  0);
      chk("rst_err",   err,   0);
      chk("rst_flags", flags, 0);
      chk("rst_sgpr",  sgpr,  0);
      gprs_zero("rst_gprs");

      vecs.push_back(mk(enc_i(OP_MOV,  1, 0, 16'h1234), 1, 32'h0000_1234, 4'h0, 0));
      vecs.push_back(mk(enc_i(OP_ADD,  2, 1, 16'h0001), 2, 32'h0000_1235, 4'h0, 0));
      vecs.push_back(mk(enc_i(OP_OR,   7, 1, 16'h00F0), 7, 32'h0000_12F4, 4'h0, 0));
      vecs.push_back(mk(enc_i(OP_AND,  8, 1, 16'h0F0F), 8, 32'h0000_0204, 4'h0, 0));
      vecs.push_back(mk(enc_i(OP_SUB,  6, 0, 16'h0001), 6, 32'hFFFF_FFFF, 4'hA, 0));
      vecs.push_back(mk(enc_r(OP_XOR,  6, 6, 6),        6, 32'h0000_0000, 4'h4, 0));
      vecs.push_back(mk(enc_i(OP_NOT,  9, 0, 16'h00FF), 9, 32'hFFFF_FF00, 4'h8, 0));
      vecs.push_back(mk(enc_i(OP_MOV, 13, 0, 16'h0000), 13, 32'h0000_0000, 4'h8, 0));
      vecs.push_back(mk(enc_r(OP_SUB, 10, 1, 2),        10, 32'hFFFF_FFFF, 4'hA, 0));
      vecs.push_back(mk(enc_r(OP_XNOR,12, 0, 0),        12, 32'hFFFF_FFFF, 4'h8, 0));
      vecs.push_back(mk(enc_r(OP_MOV,  1, 0, 10),       1, 32'hFFFF_FFFF, 4'h8, 0));
      vecs.push_back(mk(enc_r(OP_ADD,  3, 1, 1),        3, 32'hFFFF_FFFE, 4'hA, 0));
      vecs.push_back(mk(enc_i(OP_NAND,14, 1, 16'hFFFF), 14, 32'hFFFF_0000, 4'h8, 0));
      vecs.push_back(mk(enc_i(OP_NOR, 15, 7, 16'h0000), 15, 32'hFFFF_ED0B, 4'h8, 0));
      vecs.push_back(mk(enc_i(5'b11111, 1, 0, 16'h0000), 1, 32'hFFFF_FFFF, 4'h8, 1));
      vecs.push_back(mk(enc_i(OP_ADD,  2, 2, 16'h0001), 2, 32'h0000_1236, 4'h0, 0));
      vecs.push_back(mk(enc_i(OP_MOV, 20, 0, 16'h4000), 20, 32'h0000_4000, 4'h0, 0));
      dv = 32'h0000_4000;
      for (int k = 0; k < 16; k++) begin
         dv = dv << 1;
         vecs.push_back(mk(enc_r(OP_ADD, 20, 20, 20), 20, dv, 4'h0, 0));
      end
      vecs.push_back(mk(enc_r(OP_ADD, 21, 20, 20),      21, 32'h8000_0000, 4'h9, 0));
      vecs.push_back(mk(enc_i(OP_SUB, 22, 21, 16'h0001), 22, 32'h7FFF_FFFF, 4'h1, 0));
      vecs.push_back(mk(enc_r(OP_SUB, 22, 0, 21),       22, 32'h8000_0000, 4'hB, 0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));
      @(negedge clk);
      instr_valid = 1'b0;

`ifdef VPU_MUL_EN
      apply(mk(enc_i(OP_MOV, 23, 0, 16'h8000), 23, 32'h0000_8000, 4'hB, 0), "m_mov");
      apply(mk(enc_r(OP_ADD, 23, 23, 23),      23, 32'h0001_0000, 4'h0, 0), "m_dbl");
      do_mul(enc_r(OP_MUL, 4, 23, 23), 4, 32'h0, 32'h1, 4'h4, "mul_rr");
      apply(mk(enc_r(OP_MOVSGPR, 5, 0, 0),     5, 32'h0000_0001, 4'h4, 0), "movsgpr");
      do_mul(enc_i(OP_MUL, 25, 23, 16'h0003), 25, 32'h0003_0000, 32'h0, 4'h0, "mul_ri");
      @(negedge clk);
      instr_valid = 1'b0;
`else
      apply(mk(enc_i(OP_MUL, 1, 1, 16'h0003),  1, 32'hFFFF_FFFF, 4'hB, 1), "ill_mul");
      apply(mk(enc_r(OP_MOVSGPR, 1, 0, 0),     1, 32'hFFFF_FFFF, 4'hB, 1), "ill_movsgpr");
      @(negedge clk);
      instr_valid = 1'b0;
      chk("nomul_sgpr", sgpr, 0);
`endif

      done_seen = 1'b0;
`ifdef VPU_MUL_EN
      @(negedge clk);
      instr       = enc_r(OP_MUL, 24, 23, 23);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("abort_busy", instr_ready, 0);
      repeat (2) begin
         @(posedge clk); #1;
         done_seen = done_seen | done;
      end
`endif
      rst_n = 1'b0;
      #1;
      chk("abort_rst_ready", instr_ready, 1);
      chk("abort_rst_done",  done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         done_seen = done_seen | done;
      end
      chk("abort_no_done", done_seen, 0);
      chk("abort_ready",   instr_ready, 1);
      chk("abort_sgpr",    sgpr, 0);
      chk("abort_flags",   flags, 0);
      gprs_zero("abort_gprs");

      apply(mk(enc_i(OP_ADD, 1, 0, 16'h0005), 1, 32'h0000_0005, 4'h0, 0), "post_rst_add");
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_err",  err,  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vpu_exec_unit.md
VPU_EXEC_UNIT -- requirements
Module: vpu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and datapath width (>=16).
REQ-002 SHALL have parameter NREGS, default 32, GPR count (power of 2, <=32; rdst/rsrc fields use low log2(NREGS) bits).
REQ-003 SHALL have parameter MUL_LAT, default 4, multiply latency in cycles (>=1).
REQ-004 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports: instr  in  32  instruction word; instr_valid  in  1  instruction offered; instr_ready  out  1  unit can accept.
REQ-006 SHALL have ports: done  out  1  one-cycle retire pulse; err  out  1  illegal-opcode flag, valid with done.
REQ-007 SHALL have ports: flags  out  4  {sign, zero, carry, overflow}; sgpr  out  DATA_W  multiply high word.
REQ-008 SHALL have ports: dbg_raddr  in  5  debug read index; dbg_rdata  out  DATA_W  combinational GPR[dbg_raddr].

Function
REQ-009 SHALL decode opcode[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], imm[15:0]; imm zero-extended to DATA_W.
REQ-010 SHALL implement opcodes 00000 movsgpr through 01011 not with ISA semantics: mov, add, sub, mul, or, and, xor, xnor, nand, nor, not; second operand = imm if imm_mode else GPR[rsrc2].
REQ-011 SHALL use GPR[rsrc1] as first mul operand in both modes; not with imm_mode=1 yields ~imm.
REQ-012 SHALL accept an instruction on a rising clk edge where instr_valid && instr_ready.
REQ-013 SHALL implement FSM IDLE/MUL_BUSY; instr_ready=1 only in IDLE.
REQ-014 SHALL, for non-mul ops, write GPR[rdst] on the accepting edge and assert done for the next cycle; throughput one per cycle.
REQ-015 SHALL, for mul, latch operands, go to MUL_BUSY, count MUL_LAT-1 cycles, then write GPR[rdst]=product[DATA_W-1:0] and sgpr=product[2*DATA_W-1:DATA_W], assert done, return to IDLE; MUL_LAT=1 behaves as non-mul timing.
REQ-016 SHALL read sources before writing when rdst equals a source (old value used).
REQ-017 SHALL update flags on add, sub, mul and logic ops: zero/sign from result written to rdst; carry = add carry-out or sub borrow (0 otherwise); overflow = signed overflow for add/sub (0 otherwise); mov/movsgpr leave flags.
REQ-018 SHALL treat opcodes 01100-11111 as illegal: accepted, no GPR/sgpr/flags change, done and err asserted together for one cycle.
REQ-019 SHALL hold err=0 whenever done=0.
REQ-020 SHALL ignore instr while instr_valid=0 or during MUL_BUSY; sender holds instr until accepted.
REQ-021 SHALL return dbg_rdata=0 for dbg_raddr>=NREGS.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear all GPRs, sgpr, flags, done, err, multiply counter, and enter IDLE (instr_ready=1 after release).
REQ-023 SHALL abort an in-flight multiply on reset with no result written.

Configuration
REQ-024 SHALL support macro VPU_MUL_EN: defined -> mul as REQ-015; undefined -> no multiplier or MUL_BUSY logic, opcodes 00100 and 00000 treated as illegal per REQ-018, sgpr tied 0.

Structure
REQ-025 SHALL place opcode constants, instruction field positions and flag bit indices in shared package vpu_pkg.
REQ-026 SHALL implement multiplication in sub-module vpu_mul (MUL_LAT-stage, start/valid handshake).

Verification
REQ-027 SHALL cover: mov imm 0x1234 to r1, add r2=r1+imm 0x0001 -> r2=0x1235, flags zero=0 carry=0, done each following cycle.
REQ-028 SHALL cover: r1=0xFFFFFFFF, add r3=r1+r1 -> r3=0xFFFFFFFE, carry=1, overflow=0, sign=1.
REQ-029 SHALL cover: r1=0x10000, r2=0x10000, mul r4 -> instr_ready low MUL_LAT-1 cycles, r4=0, sgpr=1, zero=1; movsgpr r5 -> r5=1.
REQ-030 SHALL cover: opcode 11111 with rdst=r1 -> done=1, err=1, r1 and flags unchanged.
REQ-031 SHALL cover: rst_n low two cycles into MUL_BUSY -> all GPRs 0, sgpr 0, instr_ready=1 after release, no done.
REQ-032 SHALL cover: sub r6=r0-imm 0x0001 -> r6=0xFFFFFFFF, carry(borrow)=1; back-to-back xor r6=r6^r6 -> r6=0, zero=1.
